// File: rtl/bin2bcd.sv
// Iterative 7-bit binary to 3-digit BCD converter (double dabble, shift-and-add-3).
// One conversion per request: 7 OP cycles, then a one-cycle DONE pulse with results held on bcd2/bcd1/bcd0.
module bin2bcd (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] bin,
    output logic       ready,
    output logic       done_tick,
    output logic [3:0] bcd2,
    output logic [3:0] bcd1,
    output logic [3:0] bcd0
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OP   = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t      state_q, state_d;
    logic [6:0]  shift_q, shift_d;
    logic [3:0]  s2_q, s2_d;
    logic [3:0]  s1_q, s1_d;
    logic [3:0]  s0_q, s0_d;
    logic [2:0]  n_q, n_d;
    logic [3:0]  bcd2_q, bcd2_d;
    logic [3:0]  bcd1_q, bcd1_d;
    logic [3:0]  bcd0_q, bcd0_d;
    logic [18:0] adj_vec_s;
    logic [18:0] shifted_s;

    // A digit of 5 or more would overflow past 9 when doubled, so it is pre-corrected by +3.
    function automatic logic [3:0] dabble_adj(input logic [3:0] d);
        if (d >= 4'd5) begin
            return d + 4'd3;
        end else begin
            return d;
        end
    endfunction

    // Next-state and datapath logic for the IDLE/OP/DONE sequencer.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        s2_d      = s2_q;
        s1_d      = s1_q;
        s0_d      = s0_q;
        n_d       = n_q;
        bcd2_d    = bcd2_q;
        bcd1_d    = bcd1_q;
        bcd0_d    = bcd0_q;
        adj_vec_s = {dabble_adj(s2_q), dabble_adj(s1_q), dabble_adj(s0_q), shift_q};
        shifted_s = {adj_vec_s[17:0], 1'b0};

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = OP;
                    shift_d = bin;
                    s2_d    = 4'd0;
                    s1_d    = 4'd0;
                    s0_d    = 4'd0;
                    n_d     = 3'd7;
                end else begin
                    state_d = IDLE;
                end
            end
            OP: begin
                s2_d    = shifted_s[18:15];
                s1_d    = shifted_s[14:11];
                s0_d    = shifted_s[10:7];
                shift_d = shifted_s[6:0];
                n_d     = n_q - 3'd1;
                // Last shift: publish the post-shift digits on the same edge that enters DONE.
                if (n_q == 3'd1) begin
                    state_d = DONE;
                    bcd2_d  = shifted_s[18:15];
                    bcd1_d  = shifted_s[14:11];
                    bcd0_d  = shifted_s[10:7];
                end else begin
                    state_d = OP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shift_q <= 7'd0;
            s2_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
            n_q     <= 3'd0;
            bcd2_q  <= 4'd0;
            bcd1_q  <= 4'd0;
            bcd0_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            s2_q    <= s2_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            n_q     <= n_d;
            bcd2_q  <= bcd2_d;
            bcd1_q  <= bcd1_d;
            bcd0_q  <= bcd0_d;
        end
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign bcd2      = bcd2_q;
    assign bcd1      = bcd1_q;
    assign bcd0      = bcd0_q;

endmodule

// File: tb/tb_bin2bcd.sv
// Scoreboard bench for bin2bcd: stimulus pushes expected digits and done cycle,
// a negedge monitor pops and compares on every done_tick.
module tb_bin2bcd;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] bin;
    logic       ready;
    logic       done_tick;
    logic [3:0] bcd2, bcd1, bcd0;

    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    logic [11:0] exp_q[$];
    int          cyc_q[$];

    bin2bcd dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: result/latency on done_tick, busy length on each busy window.
    int low_cnt = 0;
    bit aborted = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            aborted = 1'b1;
        end else begin
            chk("ready_and_done", int'(ready && done_tick), 0);
            if (done_tick) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", int'(done_tick), 0);
                end else begin
                    logic [11:0] e;
                    int ec;
                    e  = exp_q.pop_front();
                    ec = cyc_q.pop_front();
                    chk("result", int'({bcd2, bcd1, bcd0}), int'(e));
                    chk("latency", cyc, ec);
                end
            end
            if (!ready) begin
                low_cnt++;
            end else begin
                if (low_cnt != 0 && !aborted) chk("busy_len", low_cnt, 8);
                low_cnt = 0;
                aborted = 1'b0;
            end
        end
    end

    task automatic wait_idle();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (ready) seen = 1'b1;
        end
        chk("idle_timeout", int'(seen), 1);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    // One-cycle start pulse; caller supplies the expected digits.
    task automatic convert(input logic [6:0] b, input logic [11:0] e);
        @(posedge clk); #1;
        bin   = b;
        start = 1'b1;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1 + 7);
        @(posedge clk); #1;
        start = 1'b0;
        wait_idle();
    endtask

    logic [6:0]  vec_bin [0:4] = '{7'd0, 7'd99, 7'd100, 7'd127, 7'd5};
    logic [11:0] vec_exp [0:4] = '{12'h000, 12'h099, 12'h100, 12'h127, 12'h005};

    initial begin
        int e1;
        reset = 1'b1;
        start = 1'b0;
        bin   = 7'd0;
        idle_cycles(2);
        reset = 1'b0;
        chk("rst_ready", int'(ready), 1);
        chk("rst_done", int'(done_tick), 0);
        chk("rst_bcd", int'({bcd2, bcd1, bcd0}), 0);

        for (int i = 0; i < 5; i++) convert(vec_bin[i], vec_exp[i]);

        for (int b = 0; b < 128; b++) begin
            convert(7'(b), 12'(((b / 100) << 8) | (((b / 10) % 10) << 4) | (b % 10)));
        end

        // Second request and bin change during OP must be ignored.
        @(posedge clk); #1;
        bin = 7'd45; start = 1'b1;
        exp_q.push_back(12'h045);
        cyc_q.push_back(cyc + 1 + 7);
        @(posedge clk); #1;
        bin = 7'd12;
        idle_cycles(4);
        start = 1'b0;
        wait_idle();
        idle_cycles(12);
        chk("ignore_hold", int'({bcd2, bcd1, bcd0}), 12'h045);

        // Reset in the 4th OP cycle aborts the conversion.
        @(posedge clk); #1;
        bin = 7'd77; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        idle_cycles(3);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort_ready", int'(ready), 1);
        chk("abort_bcd", int'({bcd2, bcd1, bcd0}), 0);
        idle_cycles(12);
        chk("abort_stays0", int'({bcd2, bcd1, bcd0}), 0);

        // Reset beats start at the same edge.
        @(posedge clk); #1;
        reset = 1'b1; start = 1'b1; bin = 7'd33;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        chk("rst_wins_ready", int'(ready), 1);
        idle_cycles(12);
        chk("rst_wins_bcd", int'({bcd2, bcd1, bcd0}), 0);

        // start held high: back-to-back conversions 9 cycles apart.
        @(posedge clk); #1;
        bin = 7'd58; start = 1'b1;
        e1 = cyc + 1;
        exp_q.push_back(12'h058); cyc_q.push_back(e1 + 7);
        exp_q.push_back(12'h063); cyc_q.push_back(e1 + 16);
        @(posedge clk); #1;
        bin = 7'd63;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (cyc >= e1 + 8 && cyc <= e1 + 15) chk("stable_058", int'({bcd2, bcd1, bcd0}), 12'h058);
            if (cyc == e1 + 9) start = 1'b0;
        end
        wait_idle();
        idle_cycles(12);
        chk("final_063", int'({bcd2, bcd1, bcd0}), 12'h063);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bin2bcd.md
BIN2BCD -- requirements
Module: bin2bcd

Interface
REQ-001 Parameters: none; all widths fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 bin  input  7  unsigned binary operand, 0..127; sampled on the accepted start edge only.
REQ-006 ready  output  1  high exactly while FSM is in IDLE.
REQ-007 done_tick  output  1  one-cycle pulse, high exactly while FSM is in DONE.
REQ-008 bcd2  output  4  hundreds digit of last completed result, 0..1.
REQ-009 bcd1  output  4  tens digit of last completed result, 0..9.
REQ-010 bcd0  output  4  units digit of last completed result, 0..9.

Function
REQ-011 Block SHALL be an iterative double-dabble (shift-and-add-3) binary-to-BCD converter, inverse of the team's bcd2bin block.
REQ-012 FSM states SHALL be IDLE, OP, DONE; any unused encoding SHALL go to IDLE next cycle.
REQ-013 IDLE: ready=1; start=1 at an edge -> load 7-bit shift reg with bin, clear internal digits s2/s1/s0 to 0, load iteration counter n=7, go to OP.
REQ-014 IDLE with start=0 -> stay IDLE; internal regs and outputs hold.
REQ-015 OP, each cycle: each internal digit >=5 gets +3 (4-bit, no carry out), then {s2,s1,s0,shift} shifts left 1 bit as a 19-bit vector, shift LSB filled with 0.
REQ-016 OP: n decrements each cycle; when decremented n==0, transition to DONE and load bcd2/bcd1/bcd0 from the post-shift digit values in the same edge.
REQ-017 OP SHALL last exactly 7 cycles.
REQ-018 DONE: done_tick=1, ready=0 for exactly one cycle, then IDLE unconditionally.
REQ-019 Latency: start accepted at edge E -> done_tick high in cycle after edge E+7; results valid on bcd* from edge E+8.
REQ-020 bcd2/bcd1/bcd0 SHALL change only on the DONE-entry edge or reset; intermediate OP values never appear on outputs.
REQ-021 start while in OP or DONE SHALL be ignored, not queued; bin changes after acceptance SHALL not affect the result.
REQ-022 start held high continuously: new conversion accepted on first IDLE cycle after each DONE, giving a 9-cycle period.
REQ-023 Every digit SHALL be a legal BCD value (0..9) at all times for any bin in 0..127.
REQ-024 ready and done_tick SHALL be decoded from state only; never both high.

Reset
REQ-025 reset=1 at an edge SHALL force IDLE, n=0, shift=0, s2/s1/s0=0, bcd2/bcd1/bcd0=0, with priority over all other inputs.
REQ-026 After reset: ready=1, done_tick=0, outputs 0.
REQ-027 reset during OP or DONE SHALL abort the conversion; no done_tick pulse and no output update for it.
REQ-028 reset and start high at the same edge: reset wins; start must be reasserted in IDLE.

Verification
REQ-029 bin=0, start 1 cycle -> done_tick exactly 8 cycles after the start edge; bcd2/1/0=0/0/0.
REQ-030 bin=99, 100, 127 in sequence -> 0/9/9, 1/0/0, 1/2/7; each with exactly one done_tick.
REQ-031 Exhaustive sweep bin=0..127 against a decimal reference model; ready low for exactly 8 cycles per conversion.
REQ-032 bin=45 accepted, then start=1 with bin=12 during OP -> result 0/4/5; second request not serviced.
REQ-033 bin=77 accepted, reset at 4th OP cycle -> no done_tick; outputs 0/0/0; ready=1 the cycle after reset.
REQ-034 start held high, bin=58 then 63 -> consecutive done_ticks 9 cycles apart; outputs 0/5/8 then 0/6/3, stable between pulses.
